n1_seq: RTL and testbench

- Sequencer for the single multiply-accumulate datapath `n1`, which computes res = nbin*sb + nbout combinationally.
- Runs one dot product of programmable length L over two operand buffers: the NBin buffer (neuron inputs) and the SB buffer (synaptic weights).
- Issues buffer reads, feeds returned operands and its own accumulator register into an external `n1` instance, and captures `n1`'s result each valid cycle.
- Presents the final sum through a valid/ready output handshake.

---
 rtl/n1_seq_if.sv | 41 ++++
 rtl/n1_seq.sv | 105 ++++++++++
 tb/tb_n1_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/n1_seq_if.sv
// Signal bundle between the n1 sequencer and its buffers, MAC and result consumer.
// Signal names are from the sequencer's point of view.
interface n1_seq_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 8
);
    logic          i_start;
    logic [AW:0]   i_len;
    logic [AW-1:0] i_nbin_base;
    logic [AW-1:0] i_sb_base;
    logic [N-1:0]  i_init;
    logic          i_stall;
    logic          o_rd_en;
    logic [AW-1:0] o_nbin_addr;
    logic [AW-1:0] o_sb_addr;
    logic [N-1:0]  i_nbin_data;
    logic [N-1:0]  i_sb_data;
    logic [N-1:0]  o_mac_nbin;
    logic [N-1:0]  o_mac_sb;
    logic [N-1:0]  o_mac_nbout;
    logic [N-1:0]  i_mac_res;
    logic [N-1:0]  o_res;
    logic          o_res_valid;
    logic          i_res_ready;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_start, i_len, i_nbin_base, i_sb_base, i_init, i_stall,
        output i_nbin_data, i_sb_data, i_mac_res, i_res_ready,
        input  o_rd_en, o_nbin_addr, o_sb_addr, o_mac_nbin, o_mac_sb, o_mac_nbout,
        input  o_res, o_res_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_len, i_nbin_base, i_sb_base, i_init, i_stall,
        input  i_nbin_data, i_sb_data, i_mac_res, i_res_ready,
        output o_rd_en, o_nbin_addr, o_sb_addr, o_mac_nbin, o_mac_sb, o_mac_nbout,
        output o_res, o_res_valid, o_busy, o_done
    );
endinterface

// File: rtl/n1_seq.sv
// Sequencer for the n1 multiply-accumulate: issues L buffer reads, feeds the external
// MAC with the returned operands and the accumulator, and hands out the final sum.
module n1_seq #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 8
) (
    input logic     i_clk,
    input logic     i_rst_n,
    n1_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

    localparam logic [AW:0]   LenOne = (AW + 1)'(1);
    localparam logic [AW-1:0] CntOne = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] nbin_base_q, nbin_base_d;
    logic [AW-1:0] sb_base_q, sb_base_d;
    logic [AW:0]   len_q, len_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          data_vld_q;
    logic          done_q, done_d;
    logic          rd_en;
    logic          last_rd;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        nbin_base_d = nbin_base_q;
        sb_base_d   = sb_base_q;
        len_d       = len_q;
        acc_d       = acc_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        last_rd     = ({1'b0, count_q} == (len_q - LenOne));

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    len_d       = bus.i_len;
                    nbin_base_d = bus.i_nbin_base;
                    sb_base_d   = bus.i_sb_base;
                    count_d     = '0;
                    state_d     = (bus.i_len == '0) ? StDrain : StIssue;
                end
            end
            StIssue: begin
                rd_en = ~bus.i_stall;
                if (rd_en) begin
                    count_d = count_q + CntOne;
                    if (last_rd) state_d = StDrain;
                end
            end
            StDrain: state_d = StOut;
            StOut: begin
                if (bus.i_res_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bias load wins; data_vld is never set in IDLE anyway.
        if (state_q == StIdle && bus.i_start) begin
            acc_d = bus.i_init;
        end else if (data_vld_q) begin
            acc_d = bus.i_mac_res;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            nbin_base_q <= '0;
            sb_base_q   <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            data_vld_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            nbin_base_q <= nbin_base_d;
            sb_base_q   <= sb_base_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            data_vld_q  <= rd_en;
            done_q      <= done_d;
        end
    end

    assign bus.o_rd_en     = rd_en;
    assign bus.o_nbin_addr = nbin_base_q + count_q;
    assign bus.o_sb_addr   = sb_base_q + count_q;
    assign bus.o_mac_nbin  = bus.i_nbin_data;
    assign bus.o_mac_sb    = bus.i_sb_data;
    assign bus.o_mac_nbout = acc_q;
    assign bus.o_res       = acc_q;
    assign bus.o_res_valid = (state_q == StOut);
    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_done      = done_q;
endmodule

// File: tb/tb_n1_seq.sv
// Directed self-checking bench for n1_seq with registered buffer models and an n1 MAC model.
module tb_n1_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    n1_seq_if #(.N(16), .AW(8)) bus ();
    n1_seq #(.N(16), .AW(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    logic [15:0] nbin_mem [256];
    logic [15:0] sb_mem   [256];

    // Buffers return data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.o_rd_en) begin
            bus.i_nbin_data <= nbin_mem[bus.o_nbin_addr];
            bus.i_sb_data   <= sb_mem[bus.o_sb_addr];
        end
    end

    assign bus.i_mac_res = 16'(bus.o_mac_nbin * bus.o_mac_sb + bus.o_mac_nbout);

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] rd_nb_q[$];
    logic [7:0] rd_sb_q[$];
    logic [7:0] trace_nb[100];
    logic       trace_rd[100];

    task automatic start_job(input logic [8:0] len, input logic [7:0] nb, input logic [7:0] sb,
                             input logic [15:0] init);
        bus.i_start     = 1'b1;
        bus.i_len       = len;
        bus.i_nbin_base = nb;
        bus.i_sb_base   = sb;
        bus.i_init      = init;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // Runs from just after edge 0 until the o_done pulse; k is the edge index.
    task automatic wait_result(input logic [31:0] stall_mask, input int ready_hold, input bit noise,
                               output int n_reads, output int valid_edge, output logic [15:0] res,
                               output bit res_stable, output int done_edge);
        n_reads = 0; valid_edge = -1; res = '0; res_stable = 1'b1; done_edge = -1;
        rd_nb_q.delete();
        rd_sb_q.delete();
        for (int k = 0; k < 100; k++) begin
            bus.i_stall = (k < 32) ? stall_mask[k] : 1'b0;
            @(negedge clk);
            trace_nb[k] = bus.o_nbin_addr;
            trace_rd[k] = bus.o_rd_en;
            if (bus.o_rd_en) begin
                n_reads++;
                rd_nb_q.push_back(bus.o_nbin_addr);
                rd_sb_q.push_back(bus.o_sb_addr);
            end
            if (bus.o_res_valid) begin
                if (valid_edge < 0) begin
                    valid_edge = k;
                    res = bus.o_res;
                end else if (bus.o_res !== res) begin
                    res_stable = 1'b0;
                end
            end
            if (bus.o_done) begin
                done_edge = k;
                break;
            end
            bus.i_res_ready = (valid_edge >= 0) && (k - valid_edge >= ready_hold);
            if (noise) begin
                bus.i_start     = 1'b1;
                bus.i_len       = 9'd5;
                bus.i_nbin_base = 8'h33;
                bus.i_sb_base   = 8'h33;
                bus.i_init      = 16'hBEEF;
            end
            @(posedge clk);
            #1;
        end
        bus.i_start     = 1'b0;
        bus.i_res_ready = 1'b0;
        bus.i_stall     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.o_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.o_rd_en); end
        n_checks++; if (bus.o_res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_res_valid); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        n_checks++; if (bus.o_res !== 16'h0) begin n_fail++; $display("FAIL reset_res: got %h want 0000", bus.o_res); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int nr, ve, de; logic [15:0] r; bit st;
        for (int i = 0; i < 4; i++) begin
            nbin_mem[8'h10 + i] = 16'(i + 1);
            sb_mem[8'h20 + i]   = 16'(i + 5);
        end
        start_job(9'd4, 8'h10, 8'h20, 16'h0);
        wait_result(32'h0, 0, 1'b0, nr, ve, r, st, de);
        n_checks++; if (nr !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d want 4", nr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_nb_q[i] !== 8'(8'h10 + i) || rd_sb_q[i] !== 8'(8'h20 + i)) begin
                n_fail++; $display("FAIL basic_addr%0d: got %h/%h want %h/%h", i, rd_nb_q[i],
                                   rd_sb_q[i], 8'(8'h10 + i), 8'(8'h20 + i));
            end
        end
        n_checks++; if (r !== 16'd70) begin n_fail++; $display("FAIL basic_res: got %0d want 70", r); end
        n_checks++; if (ve !== 5) begin n_fail++; $display("FAIL basic_valid_edge: got %0d want 5", ve); end
        n_checks++; if (de !== 6) begin n_fail++; $display("FAIL basic_done_edge: got %0d want 6", de); end
    endtask

    task automatic test_zero_len();
        int nr, ve, de; logic [15:0] r; bit st;
        start_job(9'd0, 8'h00, 8'h00, 16'h0123);
        wait_result(32'h0, 0, 1'b0, nr, ve, r, st, de);
        n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", nr); end
        n_checks++; if (r !== 16'h0123) begin n_fail++; $display("FAIL zero_res: got %h want 0123", r); end
        n_checks++; if (ve !== 1) begin n_fail++; $display("FAIL zero_valid_edge: got %0d want 1", ve); end
    endtask

    task automatic test_stall();
        int nr, ve, de; logic [15:0] r; bit st;
        for (int i = 0; i < 3; i++) begin
            nbin_mem[8'h40 + i] = 16'(i + 3);
            sb_mem[8'h50 + i]   = 16'(10 * (i + 1));
        end
        start_job(9'd3, 8'h40, 8'h50, 16'd7);
        wait_result(32'b110, 0, 1'b0, nr, ve, r, st, de);
        n_checks++; if (nr !== 3) begin n_fail++; $display("FAIL stall_reads: got %0d want 3", nr); end
        n_checks++;
        if (trace_rd[1] !== 1'b0 || trace_rd[2] !== 1'b0) begin
            n_fail++; $display("FAIL stall_rd_en: got %b%b want 00", trace_rd[1], trace_rd[2]);
        end
        n_checks++;
        if (trace_nb[1] !== 8'h41 || trace_nb[2] !== 8'h41) begin
            n_fail++; $display("FAIL stall_addr_hold: got %h,%h want 41,41", trace_nb[1], trace_nb[2]);
        end
        n_checks++;
        if (rd_nb_q[2] !== 8'h42) begin n_fail++; $display("FAIL stall_last_addr: got %h want 42", rd_nb_q[2]); end
        n_checks++; if (r !== 16'd267) begin n_fail++; $display("FAIL stall_res: got %0d want 267", r); end
        n_checks++; if (ve !== 6) begin n_fail++; $display("FAIL stall_valid_edge: got %0d want 6", ve); end
    endtask

    task automatic test_wrap();
        int nr, ve, de; logic [15:0] r; bit st;
        logic [7:0] exp_addr[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) begin
            nbin_mem[exp_addr[i]] = 16'h0100;
            sb_mem[exp_addr[i]]   = 16'h0100;
        end
        start_job(9'd4, 8'hFE, 8'hFE, 16'h0);
        wait_result(32'h0, 0, 1'b0, nr, ve, r, st, de);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_nb_q[i] !== exp_addr[i] || rd_sb_q[i] !== exp_addr[i]) begin
                n_fail++; $display("FAIL wrap_addr%0d: got %h/%h want %h", i, rd_nb_q[i], rd_sb_q[i],
                                   exp_addr[i]);
            end
        end
        n_checks++; if (r !== 16'h0) begin n_fail++; $display("FAIL wrap_res: got %h want 0000", r); end
    endtask

    task automatic test_back_to_back();
        int nr, ve, de; logic [15:0] r; bit st;
        nbin_mem[8'h80] = 16'd2; nbin_mem[8'h81] = 16'd3;
        sb_mem[8'h90]   = 16'd4; sb_mem[8'h91]   = 16'd5;
        start_job(9'd2, 8'h80, 8'h90, 16'd1);
        wait_result(32'h0, 3, 1'b1, nr, ve, r, st, de);
        n_checks++; if (nr !== 2) begin n_fail++; $display("FAIL b2b_a_reads: got %0d want 2", nr); end
        n_checks++; if (r !== 16'd24) begin n_fail++; $display("FAIL b2b_a_res: got %0d want 24", r); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL b2b_a_res_stable: got %b want 1", st); end
        n_checks++; if (ve !== 3) begin n_fail++; $display("FAIL b2b_a_valid_edge: got %0d want 3", ve); end
        n_checks++; if (de !== 7) begin n_fail++; $display("FAIL b2b_a_done_edge: got %0d want 7", de); end
        // Start of job B lands in the o_done cycle.
        start_job(9'd2, 8'h80, 8'h90, 16'h0100);
        wait_result(32'h0, 0, 1'b0, nr, ve, r, st, de);
        n_checks++; if (r !== 16'h0117) begin n_fail++; $display("FAIL b2b_b_res: got %h want 0117", r); end
        n_checks++; if (ve !== 3) begin n_fail++; $display("FAIL b2b_b_valid_edge: got %0d want 3", ve); end
    endtask

    task automatic test_reset_mid();
        int nr, ve, de; logic [15:0] r; bit st;
        bit seen;
        start_job(9'd8, 8'h10, 8'h20, 16'h5555);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.o_nbin_addr !== 8'h12) begin n_fail++; $display("FAIL rst_mid_count: got %h want 12", bus.o_nbin_addr); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.o_busy); end
        n_checks++; if (bus.o_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en: got %b want 0", bus.o_rd_en); end
        n_checks++; if (bus.o_res !== 16'h0) begin n_fail++; $display("FAIL rst_mid_res: got %h want 0000", bus.o_res); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_done || bus.o_res_valid || bus.o_busy) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: got %b want 0", seen); end
        start_job(9'd4, 8'h10, 8'h20, 16'h0);
        wait_result(32'h0, 0, 1'b0, nr, ve, r, st, de);
        n_checks++; if (r !== 16'd70) begin n_fail++; $display("FAIL rst_mid_rerun_res: got %0d want 70", r); end
        n_checks++; if (ve !== 5) begin n_fail++; $display("FAIL rst_mid_rerun_edge: got %0d want 5", ve); end
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_len       = '0;
        bus.i_nbin_base = '0;
        bus.i_sb_base   = '0;
        bus.i_init      = '0;
        bus.i_stall     = 1'b0;
        bus.i_res_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            nbin_mem[i] = '0;
            sb_mem[i]   = '0;
        end
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
